// File: rtl/ccm_pkg.sv
// Shared types and helpers for the closely-coupled memory arbiter and its address checker.
package ccm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_LSU  = 2'b01,
        OWN_DMA  = 2'b10
    } owner_e;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_FORCE = 1'b1
    } arb_state_e;

    // Encoding 2'b11 is undefined and treated as misaligned so it can never reach the DCCM.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] offset);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = (offset != 2'd3);
            SZ_WORD: ok = (offset == 2'd0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ccm_arbiter_if.sv
// LSU, DMA and DCCM signal bundle around the arbiter; slave is the arbiter's view.
interface ccm_arbiter_if;
    logic        lsu_rd_en;
    logic        lsu_wr_en;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wr_data;
    logic [1:0]  lsu_store_type;
    logic        lsu_stall;
    logic        lsu_rvalid;
    logic [31:0] lsu_rd_data;

    logic        dma_valid;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [1:0]  dma_size;
    logic        dma_ready;
    logic        dma_rvalid;
    logic [31:0] dma_rdata;
    logic        dma_err;

    logic        dccm_rd_en;
    logic        dccm_wr_en;
    logic [31:0] dccm_rd_addr;
    logic [31:0] dccm_wr_addr;
    logic [31:0] dccm_wr_data;
    logic [1:0]  store_type;
    logic [1:0]  store_offset;
    logic [31:0] dccm_rd_data;

    modport slave (
        input  lsu_rd_en, lsu_wr_en, lsu_addr, lsu_wr_data, lsu_store_type,
        output lsu_stall, lsu_rvalid, lsu_rd_data,
        input  dma_valid, dma_we, dma_addr, dma_wdata, dma_size,
        output dma_ready, dma_rvalid, dma_rdata, dma_err,
        output dccm_rd_en, dccm_wr_en, dccm_rd_addr, dccm_wr_addr, dccm_wr_data,
        output store_type, store_offset,
        input  dccm_rd_data
    );

    modport master (
        output lsu_rd_en, lsu_wr_en, lsu_addr, lsu_wr_data, lsu_store_type,
        input  lsu_stall, lsu_rvalid, lsu_rd_data,
        output dma_valid, dma_we, dma_addr, dma_wdata, dma_size,
        input  dma_ready, dma_rvalid, dma_rdata, dma_err,
        input  dccm_rd_en, dccm_wr_en, dccm_rd_addr, dccm_wr_addr, dccm_wr_data,
        input  store_type, store_offset,
        output dccm_rd_data
    );

endinterface

// File: rtl/ccm_addr_chk.sv
// Combinational window and alignment check for a byte address; kept generic for other CCM windows.
module ccm_addr_chk
    import ccm_pkg::*;
#(
    parameter logic [31:0] BASE = 32'hF004_0000,
    parameter logic [31:0] SIZE = 32'h0001_0000
) (
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    output logic        in_range,
    output logic        aligned
);

    logic [31:0] rel_addr;

    // Unsigned wrap makes addresses below BASE look huge, so one compare covers both ends.
    assign rel_addr = addr - BASE;
    assign in_range = (rel_addr < SIZE);
    assign aligned  = is_aligned(size, addr[1:0]);

endmodule

// File: rtl/ccm_arbiter.sv
// DCCM port arbiter: fixed LSU priority, starvation-forced DMA grant, DMA error responses, read-return steering.
//
// state    | meaning
// ST_ARB   | LSU wins if requesting, else DMA; counts DMA denials
// ST_FORCE | DMA granted unconditionally for one cycle, LSU stalled
module ccm_arbiter
    import ccm_pkg::*;
#(
    parameter logic [31:0] DCCM_BASE  = 32'hF004_0000,
    parameter logic [31:0] DCCM_SIZE  = 32'h0001_0000,
    parameter int          STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    ccm_arbiter_if.slave  bus
);

    localparam logic [7:0] STARVE_TC = 8'(STARVE_MAX - 1);

    arb_state_e  state, state_nxt;
    logic [7:0]  starve_cnt, starve_nxt;
    owner_e      rd_owner, rd_owner_nxt;
    logic        err_pend;

    logic        lsu_req, lsu_gnt, dma_gnt;
    logic        dma_in_range, dma_aligned, dma_bad;
    logic        dma_acc, acc_rd, acc_wr;
    logic [31:0] gnt_addr, gnt_wdata;
    logic [1:0]  gnt_size;

    assign lsu_req = bus.lsu_rd_en | bus.lsu_wr_en;

    ccm_addr_chk #(.BASE(DCCM_BASE), .SIZE(DCCM_SIZE)) u_dma_chk (
        .addr     (bus.dma_addr),
        .size     (bus.dma_size),
        .in_range (dma_in_range),
        .aligned  (dma_aligned)
    );

    assign dma_bad = !(dma_in_range && dma_aligned);

    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        lsu_gnt    = 1'b0;
        dma_gnt    = 1'b0;
        case (state)
            ST_ARB: begin
                if (lsu_req) begin
                    lsu_gnt = 1'b1;
                    if (bus.dma_valid) begin
                        if (starve_cnt == STARVE_TC) state_nxt = ST_FORCE;
                        if (starve_cnt != 8'hFF) starve_nxt = starve_cnt + 8'd1;
                    end
                end else if (bus.dma_valid) begin
                    dma_gnt = 1'b1;
                end
            end
            // Either the handshake completes or DMA withdrew; both end the forced slot.
            ST_FORCE: begin
                dma_gnt   = bus.dma_valid;
                state_nxt = ST_ARB;
            end
            default: state_nxt = ST_ARB;
        endcase
        if (dma_gnt || !bus.dma_valid) starve_nxt = 8'd0;
    end

    assign dma_acc = dma_gnt && !dma_bad;
    assign acc_rd  = (lsu_gnt && bus.lsu_rd_en) || (dma_acc && !bus.dma_we);
    assign acc_wr  = (lsu_gnt && bus.lsu_wr_en) || (dma_acc && bus.dma_we);

    assign gnt_addr  = lsu_gnt ? bus.lsu_addr       : bus.dma_addr;
    assign gnt_wdata = lsu_gnt ? bus.lsu_wr_data    : bus.dma_wdata;
    assign gnt_size  = lsu_gnt ? bus.lsu_store_type : bus.dma_size;

    assign bus.dccm_rd_en   = acc_rd;
    assign bus.dccm_wr_en   = acc_wr;
    assign bus.dccm_rd_addr = acc_rd ? gnt_addr : 32'h0;
    assign bus.dccm_wr_addr = acc_wr ? gnt_addr : 32'h0;
    assign bus.dccm_wr_data = acc_wr ? gnt_wdata : 32'h0;
    assign bus.store_type   = (acc_rd || acc_wr) ? gnt_size : 2'b00;
    assign bus.store_offset = (acc_rd || acc_wr) ? gnt_addr[1:0] : 2'b00;

    assign bus.lsu_stall = lsu_req && !lsu_gnt;
    assign bus.dma_ready = dma_gnt;

    always_comb begin
        rd_owner_nxt = OWN_NONE;
        if (lsu_gnt && bus.lsu_rd_en)      rd_owner_nxt = OWN_LSU;
        else if (dma_acc && !bus.dma_we)   rd_owner_nxt = OWN_DMA;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_ARB;
            starve_cnt <= 8'd0;
            rd_owner   <= OWN_NONE;
            err_pend   <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            rd_owner   <= rd_owner_nxt;
            err_pend   <= dma_gnt && dma_bad;
        end
    end

    // Return data is passed straight through from the DCCM, steered by the registered owner.
    assign bus.lsu_rvalid  = (rd_owner == OWN_LSU);
    assign bus.lsu_rd_data = (rd_owner == OWN_LSU) ? bus.dccm_rd_data : 32'h0;
    assign bus.dma_rvalid  = (rd_owner == OWN_DMA) || err_pend;
    assign bus.dma_rdata   = (rd_owner == OWN_DMA) ? bus.dccm_rd_data : 32'h0;
    assign bus.dma_err     = err_pend;

endmodule

// File: tb/tb_ccm_arbiter.sv
// Directed bench for ccm_arbiter: a one-cycle DCCM read model and per-scenario inline checks.
module tb_ccm_arbiter;
    import ccm_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    ccm_arbiter_if bus();

    ccm_arbiter #(
        .DCCM_BASE  (32'hF004_0000),
        .DCCM_SIZE  (32'h0001_0000),
        .STARVE_MAX (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    always @(posedge clk)
        bus.dccm_rd_data <= bus.dccm_rd_en ? mem_val(bus.dccm_rd_addr) : 32'h0;

    always @(posedge clk)
        if (!rst) assert (!(bus.lsu_rd_en && bus.lsu_wr_en))
            else $error("illegal simultaneous lsu_rd_en and lsu_wr_en");

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [170:0] all_outs();
        return {bus.lsu_stall, bus.lsu_rvalid, bus.lsu_rd_data, bus.dma_ready, bus.dma_rvalid,
                bus.dma_rdata, bus.dma_err, bus.dccm_rd_en, bus.dccm_wr_en, bus.dccm_rd_addr,
                bus.dccm_wr_addr, bus.dccm_wr_data, bus.store_type, bus.store_offset};
    endfunction

    task automatic idle_inputs();
        bus.lsu_rd_en = 0; bus.lsu_wr_en = 0; bus.lsu_addr = 0; bus.lsu_wr_data = 0; bus.lsu_store_type = 0;
        bus.dma_valid = 0; bus.dma_we = 0; bus.dma_addr = 0; bus.dma_wdata = 0; bus.dma_size = 0;
    endtask

    task automatic lsu_read(input logic [31:0] a);
        bus.lsu_rd_en = 1; bus.lsu_wr_en = 0; bus.lsu_addr = a; bus.lsu_store_type = SZ_WORD;
    endtask

    task automatic dma_req(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        bus.dma_valid = 1; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = d; bus.dma_size = sz;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (all_outs() !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h exp 0", all_outs()); end
        n_checks++; if (dut.state !== ST_ARB) begin n_fail++; $display("FAIL reset_state: got %0d exp ARB", dut.state); end
        n_checks++; if (dut.starve_cnt !== 8'd0 || dut.rd_owner !== OWN_NONE) begin
            n_fail++; $display("FAIL reset_cnt_owner: got %0d/%0d exp 0/NONE", dut.starve_cnt, dut.rd_owner); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lsu_read();
        lsu_read(32'hF004_0010);
        #1;
        n_checks++; if (bus.dccm_rd_en !== 1'b1 || bus.dccm_rd_addr !== 32'hF004_0010 || bus.dccm_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL lsu_rd_issue: got en=%b addr=%h exp en=1 addr=f0040010", bus.dccm_rd_en, bus.dccm_rd_addr); end
        n_checks++; if (bus.lsu_stall !== 1'b0) begin n_fail++; $display("FAIL lsu_rd_stall: got %b exp 0", bus.lsu_stall); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if (bus.lsu_rvalid !== 1'b1 || bus.lsu_rd_data !== mem_val(32'hF004_0010)) begin
            n_fail++; $display("FAIL lsu_rd_return: got v=%b d=%h exp v=1 d=%h", bus.lsu_rvalid, bus.lsu_rd_data, mem_val(32'hF004_0010)); end
        n_checks++; if (bus.dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL lsu_rd_dma_rvalid: got %b exp 0", bus.dma_rvalid); end
        @(negedge clk);
    endtask

    task automatic test_lsu_write();
        bus.lsu_wr_en = 1; bus.lsu_addr = 32'hF004_0031; bus.lsu_wr_data = 32'h0000_00A5; bus.lsu_store_type = SZ_BYTE;
        #1;
        n_checks++; if ({bus.dccm_wr_en, bus.dccm_rd_en, bus.store_type, bus.store_offset} !== 6'b10_00_01 ||
                        bus.dccm_wr_addr !== 32'hF004_0031 || bus.dccm_wr_data !== 32'h0000_00A5) begin
            n_fail++; $display("FAIL lsu_wr_byte: got we=%b re=%b st=%b off=%b a=%h d=%h exp 1 0 00 01 f0040031 a5",
                bus.dccm_wr_en, bus.dccm_rd_en, bus.store_type, bus.store_offset, bus.dccm_wr_addr, bus.dccm_wr_data); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if (bus.lsu_rvalid !== 1'b0) begin n_fail++; $display("FAIL lsu_wr_no_rvalid: got %b exp 0", bus.lsu_rvalid); end
        @(negedge clk);
    endtask

    task automatic test_dma_write();
        dma_req(1'b1, 32'hF004_0020, 32'hDEADBEEF, SZ_WORD);
        #1;
        n_checks++; if (bus.dma_ready !== 1'b1) begin n_fail++; $display("FAIL dma_wr_ready: got %b exp 1", bus.dma_ready); end
        n_checks++; if ({bus.dccm_wr_en, bus.dccm_rd_en, bus.store_type, bus.store_offset} !== 6'b10_10_00 ||
                        bus.dccm_wr_addr !== 32'hF004_0020 || bus.dccm_wr_data !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL dma_wr_issue: got we=%b re=%b st=%b off=%b a=%h d=%h exp 1 0 10 00 f0040020 deadbeef",
                bus.dccm_wr_en, bus.dccm_rd_en, bus.store_type, bus.store_offset, bus.dccm_wr_addr, bus.dccm_wr_data); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if (bus.dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL dma_wr_no_resp: got %b exp 0", bus.dma_rvalid); end
        @(negedge clk);
    endtask

    task automatic test_starvation();
        lsu_read(32'hF004_0100);
        dma_req(1'b0, 32'hF004_0200, 32'h0, SZ_WORD);
        for (int i = 1; i <= 8; i++) begin
            #1;
            n_checks++; if (bus.lsu_stall !== 1'b0 || bus.dma_ready !== 1'b0 || bus.dccm_rd_addr !== 32'hF004_0100) begin
                n_fail++; $display("FAIL starve_lsu_cycle%0d: got stall=%b ready=%b addr=%h exp 0 0 f0040100",
                    i, bus.lsu_stall, bus.dma_ready, bus.dccm_rd_addr); end
            @(negedge clk);
        end
        #1;
        n_checks++; if (bus.dma_ready !== 1'b1 || bus.lsu_stall !== 1'b1 || bus.dccm_rd_addr !== 32'hF004_0200) begin
            n_fail++; $display("FAIL starve_force: got ready=%b stall=%b addr=%h exp 1 1 f0040200",
                bus.dma_ready, bus.lsu_stall, bus.dccm_rd_addr); end
        @(negedge clk);
        bus.dma_valid = 0;
        #1;
        n_checks++; if (bus.lsu_stall !== 1'b0 || bus.dccm_rd_addr !== 32'hF004_0100) begin
            n_fail++; $display("FAIL starve_lsu_resume: got stall=%b addr=%h exp 0 f0040100", bus.lsu_stall, bus.dccm_rd_addr); end
        n_checks++; if (bus.dma_rvalid !== 1'b1 || bus.dma_rdata !== mem_val(32'hF004_0200) || bus.lsu_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL starve_dma_return: got v=%b d=%h lv=%b exp 1 %h 0",
                bus.dma_rvalid, bus.dma_rdata, bus.lsu_rvalid, mem_val(32'hF004_0200)); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if (bus.lsu_rvalid !== 1'b1 || bus.lsu_rd_data !== mem_val(32'hF004_0100)) begin
            n_fail++; $display("FAIL starve_lsu_return: got v=%b d=%h exp 1 %h", bus.lsu_rvalid, bus.lsu_rd_data, mem_val(32'hF004_0100)); end
        @(negedge clk);
    endtask

    task automatic test_force_drop();
        lsu_read(32'hF004_0104);
        dma_req(1'b0, 32'hF004_0204, 32'h0, SZ_WORD);
        repeat (8) @(negedge clk);
        bus.dma_valid = 0;
        #1;
        n_checks++; if (bus.lsu_stall !== 1'b1 || bus.dccm_rd_en !== 1'b0 || bus.dma_ready !== 1'b0) begin
            n_fail++; $display("FAIL force_drop_nogrant: got stall=%b re=%b ready=%b exp 1 0 0", bus.lsu_stall, bus.dccm_rd_en, bus.dma_ready); end
        @(negedge clk);
        #1;
        n_checks++; if (bus.lsu_stall !== 1'b0 || bus.dccm_rd_en !== 1'b1 || bus.dma_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL force_drop_resume: got stall=%b re=%b dv=%b exp 0 1 0", bus.lsu_stall, bus.dccm_rd_en, bus.dma_rvalid); end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_dma_misaligned();
        dma_req(1'b0, 32'hF004_0003, 32'h0, SZ_HALF);
        #1;
        n_checks++; if (bus.dma_ready !== 1'b1 || bus.dccm_rd_en !== 1'b0) begin
            n_fail++; $display("FAIL half_off3_issue: got ready=%b re=%b exp 1 0", bus.dma_ready, bus.dccm_rd_en); end
        @(negedge clk);
        dma_req(1'b1, 32'hF004_0022, 32'h1234_5678, SZ_WORD);
        #1;
        n_checks++; if ({bus.dma_rvalid, bus.dma_err} !== 2'b11 || bus.dma_rdata !== 32'h0) begin
            n_fail++; $display("FAIL half_off3_resp: got v=%b e=%b d=%h exp 1 1 0", bus.dma_rvalid, bus.dma_err, bus.dma_rdata); end
        n_checks++; if (bus.dma_ready !== 1'b1 || bus.dccm_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL word_off2_wr_issue: got ready=%b we=%b exp 1 0", bus.dma_ready, bus.dccm_wr_en); end
        @(negedge clk);
        dma_req(1'b0, 32'hF004_0042, 32'h0, SZ_HALF);
        #1;
        n_checks++; if ({bus.dma_rvalid, bus.dma_err} !== 2'b11) begin
            n_fail++; $display("FAIL word_off2_wr_resp: got v=%b e=%b exp 1 1", bus.dma_rvalid, bus.dma_err); end
        n_checks++; if (bus.dccm_rd_en !== 1'b1 || bus.store_type !== SZ_HALF || bus.store_offset !== 2'd2) begin
            n_fail++; $display("FAIL half_off2_issue: got re=%b st=%b off=%b exp 1 01 10", bus.dccm_rd_en, bus.store_type, bus.store_offset); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if ({bus.dma_rvalid, bus.dma_err} !== 2'b10 || bus.dma_rdata !== mem_val(32'hF004_0042)) begin
            n_fail++; $display("FAIL half_off2_resp: got v=%b e=%b d=%h exp 1 0 %h", bus.dma_rvalid, bus.dma_err, bus.dma_rdata, mem_val(32'hF004_0042)); end
        @(negedge clk);
    endtask

    task automatic test_dma_out_of_range();
        lsu_read(32'hF004_0010);
        dma_req(1'b0, 32'h0000_1000, 32'h0, SZ_WORD);
        #1;
        n_checks++; if (bus.dccm_rd_en !== 1'b1 || bus.dccm_rd_addr !== 32'hF004_0010 || bus.dma_ready !== 1'b0) begin
            n_fail++; $display("FAIL oor_lsu_issue: got re=%b a=%h ready=%b exp 1 f0040010 0", bus.dccm_rd_en, bus.dccm_rd_addr, bus.dma_ready); end
        @(negedge clk);
        bus.lsu_rd_en = 0;
        #1;
        n_checks++; if (bus.lsu_rvalid !== 1'b1 || bus.lsu_rd_data !== mem_val(32'hF004_0010)) begin
            n_fail++; $display("FAIL oor_lsu_return: got v=%b d=%h exp 1 %h", bus.lsu_rvalid, bus.lsu_rd_data, mem_val(32'hF004_0010)); end
        n_checks++; if (bus.dma_ready !== 1'b1 || bus.dccm_rd_en !== 1'b0) begin
            n_fail++; $display("FAIL oor_dma_issue: got ready=%b re=%b exp 1 0", bus.dma_ready, bus.dccm_rd_en); end
        @(negedge clk);
        dma_req(1'b0, 32'hF004_FFFC, 32'h0, SZ_WORD);
        #1;
        n_checks++; if ({bus.dma_rvalid, bus.dma_err, bus.lsu_rvalid} !== 3'b110 || bus.dma_rdata !== 32'h0) begin
            n_fail++; $display("FAIL oor_dma_resp: got v=%b e=%b lv=%b d=%h exp 1 1 0 0", bus.dma_rvalid, bus.dma_err, bus.lsu_rvalid, bus.dma_rdata); end
        n_checks++; if (bus.dccm_rd_en !== 1'b1 || bus.dccm_rd_addr !== 32'hF004_FFFC) begin
            n_fail++; $display("FAIL top_word_issue: got re=%b a=%h exp 1 f004fffc", bus.dccm_rd_en, bus.dccm_rd_addr); end
        @(negedge clk);
        dma_req(1'b0, 32'hF005_0000, 32'h0, SZ_BYTE);
        #1;
        n_checks++; if (bus.dma_ready !== 1'b1 || bus.dccm_rd_en !== 1'b0) begin
            n_fail++; $display("FAIL past_end_issue: got ready=%b re=%b exp 1 0", bus.dma_ready, bus.dccm_rd_en); end
        @(negedge clk);
        dma_req(1'b0, 32'hF003_FFFF, 32'h0, SZ_BYTE);
        #1;
        n_checks++; if ({bus.dma_rvalid, bus.dma_err} !== 2'b11 || bus.dccm_rd_en !== 1'b0) begin
            n_fail++; $display("FAIL below_base: got v=%b e=%b re=%b exp 1 1 0", bus.dma_rvalid, bus.dma_err, bus.dccm_rd_en); end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        lsu_read(32'hF004_0A00);
        @(negedge clk);
        bus.lsu_rd_en = 0;
        dma_req(1'b0, 32'hF004_0B00, 32'h0, SZ_WORD);
        #1;
        n_checks++; if (bus.lsu_rvalid !== 1'b1 || bus.lsu_rd_data !== mem_val(32'hF004_0A00) || bus.dccm_rd_addr !== 32'hF004_0B00) begin
            n_fail++; $display("FAIL b2b_first: got lv=%b ld=%h ra=%h exp 1 %h f0040b00", bus.lsu_rvalid, bus.lsu_rd_data, bus.dccm_rd_addr, mem_val(32'hF004_0A00)); end
        @(negedge clk);
        bus.dma_valid = 0;
        lsu_read(32'hF004_0C00);
        #1;
        n_checks++; if ({bus.dma_rvalid, bus.lsu_rvalid} !== 2'b10 || bus.dma_rdata !== mem_val(32'hF004_0B00)) begin
            n_fail++; $display("FAIL b2b_second: got dv=%b lv=%b dd=%h exp 1 0 %h", bus.dma_rvalid, bus.lsu_rvalid, bus.dma_rdata, mem_val(32'hF004_0B00)); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if ({bus.dma_rvalid, bus.lsu_rvalid} !== 2'b01 || bus.lsu_rd_data !== mem_val(32'hF004_0C00)) begin
            n_fail++; $display("FAIL b2b_third: got dv=%b lv=%b ld=%h exp 0 1 %h", bus.dma_rvalid, bus.lsu_rvalid, bus.lsu_rd_data, mem_val(32'hF004_0C00)); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        dma_req(1'b0, 32'hF004_0040, 32'h0, SZ_WORD);
        #1;
        n_checks++; if (bus.dma_ready !== 1'b1 || bus.dccm_rd_en !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_issue: got ready=%b re=%b exp 1 1", bus.dma_ready, bus.dccm_rd_en); end
        @(posedge clk);
        #1;
        idle_inputs();
        rst = 1'b1;
        #1;
        n_checks++; if (all_outs() !== '0) begin n_fail++; $display("FAIL rstmid_outputs: got %h exp 0", all_outs()); end
        n_checks++; if (dut.state !== ST_ARB || dut.rd_owner !== OWN_NONE) begin
            n_fail++; $display("FAIL rstmid_state: got %0d/%0d exp ARB/NONE", dut.state, dut.rd_owner); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_checks++; if (bus.dma_rvalid !== 1'b0 || dut.state !== ST_ARB) begin
            n_fail++; $display("FAIL rstmid_after: got dv=%b state=%0d exp 0 ARB", bus.dma_rvalid, dut.state); end
        lsu_read(32'hF004_0044);
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if (bus.lsu_rvalid !== 1'b1 || bus.lsu_rd_data !== mem_val(32'hF004_0044)) begin
            n_fail++; $display("FAIL rstmid_recover: got v=%b d=%h exp 1 %h", bus.lsu_rvalid, bus.lsu_rd_data, mem_val(32'hF004_0044)); end
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_lsu_read();
        test_lsu_write();
        test_dma_write();
        test_starvation();
        test_force_drop();
        test_dma_misaligned();
        test_dma_out_of_range();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
